// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter: two-requester round-robin arbiter in front of a
// display pixel write port. A request is accepted in IDLE with a one-cycle
// ready pulse. The pixel is held on the write port until the display takes
// it or the wait budget expires.
// Optional feature: define PIXEL_BOUNDS_CHECK_EN to drop off-screen pixels
// (they are accepted but never issued) and count them in dropCount.
module pixel_write_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LCD_WIDTH      = 240,
    parameter int unsigned LCD_HEIGHT     = 320
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req0Valid,
    input  logic        req1Valid,
    output logic        req0Ready,
    output logic        req1Ready,
    input  logic [7:0]  req0XAddr,
    input  logic [8:0]  req0YAddr,
    input  logic [15:0] req0Data,
    input  logic [7:0]  req1XAddr,
    input  logic [8:0]  req1YAddr,
    input  logic [15:0] req1Data,
    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady,
    output logic        grantId,
    output logic        busy,
    output logic        timeoutError,
    output logic [7:0]  dropCount
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] wait_q, wait_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] data_q, data_d;
    logic        gnt_q, gnt_d;
    logic        terr_q, terr_d;
    logic [7:0]  drop_q, drop_d;

    logic        sel;
    logic        accept;
    logic [7:0]  sel_x;
    logic [8:0]  sel_y;
    logic [15:0] sel_data;

    // Pick the winner: pointer breaks ties, a lone valid always wins.
    always_comb begin
        sel      = (req0Valid && req1Valid) ? ptr_q : req1Valid;
        accept   = (state_q == IDLE) && (req0Valid || req1Valid);
        sel_x    = sel ? req1XAddr : req0XAddr;
        sel_y    = sel ? req1YAddr : req0YAddr;
        sel_data = sel ? req1Data  : req0Data;
    end

    // Ready pulses come straight from the IDLE decision; held low during reset.
    assign req0Ready = resetn && accept && !sel;
    assign req1Ready = resetn && accept &&  sel;

    // Next-state logic for the IDLE/ISSUE controller and its side state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wait_d  = wait_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        terr_d  = terr_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d = ~sel;
`ifdef PIXEL_BOUNDS_CHECK_EN
                    if ((32'(sel_x) >= LCD_WIDTH) || (32'(sel_y) >= LCD_HEIGHT)) begin
                        // Off-screen: consume the request, never issue it.
                        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    end else begin
                        state_d = ISSUE;
                        wait_d  = 16'd0;
                        x_d     = sel_x;
                        y_d     = sel_y;
                        data_d  = sel_data;
                        gnt_d   = sel;
                    end
`else
                    state_d = ISSUE;
                    wait_d  = 16'd0;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    data_d  = sel_data;
                    gnt_d   = sel;
`endif
                end
            end
            ISSUE: begin
                if (pixelReady) begin
                    // Ready on the last budget cycle still counts as a transfer.
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-pixel registers, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            wait_q  <= 16'd0;
            x_q     <= 8'd0;
            y_q     <= 9'd0;
            data_q  <= 16'd0;
            gnt_q   <= 1'b0;
            terr_q  <= 1'b0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wait_q  <= wait_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            terr_q  <= terr_d;
            drop_q  <= drop_d;
        end
    end

    assign pixelWrite   = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign xAddr        = x_q;
    assign yAddr        = y_q;
    assign pixelData    = data_q;
    assign grantId      = gnt_q;
    assign timeoutError = terr_q;
    assign dropCount    = drop_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter (TIMEOUT_CYCLES=8). Inputs change
// on the falling edge; outputs are sampled 1 time unit later.
module tb_pixel_write_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic        req0Ready, req1Ready;
    logic [7:0]  req0XAddr = '0, req1XAddr = '0;
    logic [8:0]  req0YAddr = '0, req1YAddr = '0;
    logic [15:0] req0Data = '0, req1Data = '0;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady = 1'b0;
    logic        grantId, busy, timeoutError;
    logic [7:0]  dropCount;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pixel_write_arbiter #(.TIMEOUT_CYCLES(8), .LCD_WIDTH(240), .LCD_HEIGHT(320)) dut (
        .clock(clock), .resetn(resetn),
        .req0Valid(req0Valid), .req1Valid(req1Valid),
        .req0Ready(req0Ready), .req1Ready(req1Ready),
        .req0XAddr(req0XAddr), .req0YAddr(req0YAddr), .req0Data(req0Data),
        .req1XAddr(req1XAddr), .req1YAddr(req1YAddr), .req1Data(req1Data),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .grantId(grantId), .busy(busy), .timeoutError(timeoutError),
        .dropCount(dropCount)
    );

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        req0Valid = 1'b0; req1Valid = 1'b0; pixelReady = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        resetn = 1'b0;
        req0Valid = 1'b1; req1Valid = 1'b1;
        #1;
        total++;
        if ({req0Ready, req1Ready, pixelWrite, busy, grantId, timeoutError} !== 6'b0 ||
            xAddr !== 8'd0 || yAddr !== 9'd0 || pixelData !== 16'd0 || dropCount !== 8'd0) begin
            bad++;
            $display("FAIL reset_values: r0=%b r1=%b pw=%b busy=%b gnt=%b terr=%b x=%0d y=%0d d=%h drop=%0d, required all zero",
                     req0Ready, req1Ready, pixelWrite, busy, grantId, timeoutError, xAddr, yAddr, pixelData, dropCount);
        end
        req0Valid = 1'b0; req1Valid = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd10; req0YAddr = 9'd20; req0Data = 16'hF800; pixelReady = 1'b1;
        #1;
        total++;
        if (req0Ready !== 1'b1 || req1Ready !== 1'b0 || pixelWrite !== 1'b0) begin
            bad++;
            $display("FAIL single_accept: r0=%b r1=%b pw=%b, required 1 0 0", req0Ready, req1Ready, pixelWrite);
        end
        @(negedge clock);
        req0Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b1 || xAddr !== 8'd10 || yAddr !== 9'd20 || pixelData !== 16'hF800 ||
            grantId !== 1'b0 || busy !== 1'b1 || req0Ready !== 1'b0) begin
            bad++;
            $display("FAIL single_issue: pw=%b x=%0d y=%0d d=%h gnt=%b busy=%b r0=%b, required 1 10 20 f800 0 1 0",
                     pixelWrite, xAddr, yAddr, pixelData, grantId, busy, req0Ready);
        end
        @(negedge clock);
        #1;
        total++;
        if (pixelWrite !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done: pw=%b busy=%b, required 0 0", pixelWrite, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd1; req0YAddr = 9'd1; req0Data = 16'hAAAA;
        req1Valid = 1'b1; req1XAddr = 8'd2; req1YAddr = 9'd2; req1Data = 16'h5555;
        pixelReady = 1'b1;
        exp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            total++;
            if (k % 2 == 0) begin
                if ({req1Ready, req0Ready} !== (exp ? 2'b10 : 2'b01) || pixelWrite !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_accept[%0d]: r1r0=%b pw=%b, required %b 0", k, {req1Ready, req0Ready},
                             pixelWrite, exp ? 2'b10 : 2'b01);
                end
            end else begin
                if (pixelWrite !== 1'b1 || grantId !== exp || pixelData !== (exp ? 16'h5555 : 16'hAAAA) ||
                    {req1Ready, req0Ready} !== 2'b00) begin
                    bad++;
                    $display("FAIL rr_issue[%0d]: pw=%b gnt=%b d=%h rdy=%b, required 1 %b %h 00", k, pixelWrite,
                             grantId, pixelData, {req1Ready, req0Ready}, exp, exp ? 16'h5555 : 16'hAAAA);
                end
                exp = ~exp;
            end
        end
        req0Valid = 1'b0; req1Valid = 1'b0;
    endtask

    task automatic test_stall();
        int pw_cycles;
        int xfers;
        do_reset();
        @(negedge clock);
        req1Valid = 1'b1; req1XAddr = 8'd3; req1YAddr = 9'd4; req1Data = 16'h1234; pixelReady = 1'b0;
        #1;
        total++;
        if (req1Ready !== 1'b1 || req0Ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_accept: r1=%b r0=%b, required 1 0", req1Ready, req0Ready);
        end
        pw_cycles = 0;
        xfers = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            req1Valid = 1'b0;
            req0Valid = 1'b1; req0XAddr = 8'd9; req0YAddr = 9'd9; req0Data = 16'h9999;
            pixelReady = (c == 6);
            #1;
            if (pixelWrite) pw_cycles++;
            if (pixelWrite && pixelReady) xfers++;
            if (c <= 6) begin
                total++;
                if (pixelWrite !== 1'b1 || xAddr !== 8'd3 || yAddr !== 9'd4 || pixelData !== 16'h1234 ||
                    grantId !== 1'b1 || {req1Ready, req0Ready} !== 2'b00) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: pw=%b x=%0d y=%0d d=%h gnt=%b rdy=%b, required 1 3 4 1234 1 00",
                             c, pixelWrite, xAddr, yAddr, pixelData, grantId, {req1Ready, req0Ready});
                end
            end else begin
                total++;
                if (pixelWrite !== 1'b0 || timeoutError !== 1'b0 || req0Ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_done: pw=%b terr=%b r0=%b, required 0 0 1", pixelWrite, timeoutError, req0Ready);
                end
            end
        end
        total++;
        if (pw_cycles != 6 || xfers != 1) begin
            bad++;
            $display("FAIL stall_counts: pw_cycles=%0d xfers=%0d, required 6 1", pw_cycles, xfers);
        end
        req0Valid = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd1; req0YAddr = 9'd2; req0Data = 16'h0003; pixelReady = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            req0Valid = 1'b0;
            #1;
            total++;
            if (c <= 8) begin
                if (pixelWrite !== 1'b1 || timeoutError !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_wait[%0d]: pw=%b terr=%b, required 1 0", c, pixelWrite, timeoutError);
                end
            end else if (pixelWrite !== 1'b0 || timeoutError !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL timeout_hit: pw=%b terr=%b busy=%b, required 0 1 0", pixelWrite, timeoutError, busy);
            end
        end
        // Sticky across idle time and a later good transfer.
        @(negedge clock);
        req1Valid = 1'b1; pixelReady = 1'b1;
        @(negedge clock);
        req1Valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        total++;
        if (timeoutError !== 1'b1 || pixelWrite !== 1'b0) begin
            bad++;
            $display("FAIL timeout_sticky: terr=%b pw=%b, required 1 0", timeoutError, pixelWrite);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (timeoutError !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: terr=%b, required 0", timeoutError);
        end
        resetn = 1'b1;
    endtask

    task automatic test_timeout_edge();
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; pixelReady = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            req0Valid = 1'b0;
            pixelReady = (c == 8);
        end
        #1;
        total++;
        if (pixelWrite !== 1'b0 || timeoutError !== 1'b0) begin
            bad++;
            $display("FAIL timeout_edge: pw=%b terr=%b, required 0 0", pixelWrite, timeoutError);
        end
        pixelReady = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd77; req0YAddr = 9'd88; req0Data = 16'hBEEF; pixelReady = 1'b0;
        @(negedge clock);
        req0Valid = 1'b0;
        @(negedge clock);
        #1;
        total++;
        if (pixelWrite !== 1'b1 || xAddr !== 8'd77) begin
            bad++;
            $display("FAIL mid_issue_pre: pw=%b x=%0d, required 1 77", pixelWrite, xAddr);
        end
        resetn = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b0 || busy !== 1'b0 || xAddr !== 8'd0 || yAddr !== 9'd0 ||
            pixelData !== 16'd0 || grantId !== 1'b0) begin
            bad++;
            $display("FAIL mid_issue_abort: pw=%b busy=%b x=%0d y=%0d d=%h gnt=%b, required all zero",
                     pixelWrite, busy, xAddr, yAddr, pixelData, grantId);
        end
        @(negedge clock);
        resetn = 1'b1;
        req0Valid = 1'b1; req1Valid = 1'b1; pixelReady = 1'b1;
        #1;
        total++;
        if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_issue_first: r0=%b r1=%b, required 1 0", req0Ready, req1Ready);
        end
        @(negedge clock);
        req0Valid = 1'b0; req1Valid = 1'b0;
    endtask

    task automatic test_edge_coords();
        do_reset();
        @(negedge clock);
        req1Valid = 1'b1; req1XAddr = 8'd239; req1YAddr = 9'd319; req1Data = 16'h07E0; pixelReady = 1'b1;
        @(negedge clock);
        req1Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b1 || xAddr !== 8'd239 || yAddr !== 9'd319 || grantId !== 1'b1 || dropCount !== 8'd0) begin
            bad++;
            $display("FAIL edge_coords: pw=%b x=%0d y=%0d gnt=%b drop=%0d, required 1 239 319 1 0",
                     pixelWrite, xAddr, yAddr, grantId, dropCount);
        end
    endtask

`ifdef PIXEL_BOUNDS_CHECK_EN
    task automatic test_bounds();
        int pw_seen;
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd240; req0YAddr = 9'd5; pixelReady = 1'b1;
        #1;
        total++;
        if (req0Ready !== 1'b1) begin
            bad++;
            $display("FAIL bounds_ready: r0=%b, required 1", req0Ready);
        end
        @(negedge clock);
        req0Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b0 || busy !== 1'b0 || dropCount !== 8'd1) begin
            bad++;
            $display("FAIL bounds_drop: pw=%b busy=%b drop=%0d, required 0 0 1", pixelWrite, busy, dropCount);
        end
        // y out of range as well.
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd5; req0YAddr = 9'd320;
        @(negedge clock);
        req0Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b0 || dropCount !== 8'd2) begin
            bad++;
            $display("FAIL bounds_y: pw=%b drop=%0d, required 0 2", pixelWrite, dropCount);
        end
        // Saturation after 300 dropped requests.
        do_reset();
        pw_seen = 0;
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd240; req0YAddr = 9'd5;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #1;
            if (pixelWrite) pw_seen++;
        end
        req0Valid = 1'b0;
        total++;
        if (dropCount !== 8'd255 || pw_seen != 0) begin
            bad++;
            $display("FAIL bounds_saturate: drop=%0d pw_seen=%0d, required 255 0", dropCount, pw_seen);
        end
        // Pointer still advances past a dropped request.
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd240; req0YAddr = 9'd5;
        req1Valid = 1'b1; req1XAddr = 8'd7; req1YAddr = 9'd8; req1Data = 16'h00FF;
        #1;
        total++;
        if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
            bad++;
            $display("FAIL bounds_ptr_first: r0=%b r1=%b, required 1 0", req0Ready, req1Ready);
        end
        @(negedge clock);
        #1;
        total++;
        if (pixelWrite !== 1'b0 || req1Ready !== 1'b1 || req0Ready !== 1'b0) begin
            bad++;
            $display("FAIL bounds_ptr_next: pw=%b r1=%b r0=%b, required 0 1 0", pixelWrite, req1Ready, req0Ready);
        end
        @(negedge clock);
        req0Valid = 1'b0; req1Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b1 || grantId !== 1'b1 || xAddr !== 8'd7) begin
            bad++;
            $display("FAIL bounds_ptr_issue: pw=%b gnt=%b x=%0d, required 1 1 7", pixelWrite, grantId, xAddr);
        end
    endtask
`else
    task automatic test_bounds();
        do_reset();
        @(negedge clock);
        req0Valid = 1'b1; req0XAddr = 8'd240; req0YAddr = 9'd5; req0Data = 16'h001F; pixelReady = 1'b1;
        @(negedge clock);
        req0Valid = 1'b0;
        #1;
        total++;
        if (pixelWrite !== 1'b1 || xAddr !== 8'd240 || dropCount !== 8'd0) begin
            bad++;
            $display("FAIL unchecked_issue: pw=%b x=%0d drop=%0d, required 1 240 0", pixelWrite, xAddr, dropCount);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_issue();
        test_edge_coords();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
